// File: rtl/typing_scorer.sv
// Typing-run statistics producer: counts keys/correct keys/seconds while state==2, then
// derives wpm and accuracy with one shared restoring divider and pulses finish.
module typing_scorer #(
   parameter int CNT_W   = 12,
   parameter int SEC_W   = 10,
   parameter int DIVD_W  = 20,
   parameter int MAX_WPM = 999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state,
   input  logic       key_valid,
   input  logic       key_correct,
   input  logic       sec_tick,
   output logic [9:0] wpm,
   output logic [9:0] acc,
   output logic       finish,
   output logic       busy
);

   localparam int DVS_W  = (CNT_W > SEC_W) ? CNT_W : SEC_W;
   localparam int ITER_W = $clog2(DIVD_W);

   typedef enum logic [2:0] {IDLE, RUN, DIV_W, DIV_A, DONE} fsm_t;

   fsm_t              fsm_q;
   logic [2:0]        state_prev_q;
   logic              stop_q;
   logic [CNT_W-1:0]  total_q, correct_q;
   logic [SEC_W-1:0]  secs_q;
   logic [DVS_W-1:0]  rem_q, dvs_q;
   logic [DIVD_W-1:0] quo_q;
   logic [ITER_W-1:0] iter_q;
   logic [9:0]        wpm_q, acc_q;
   logic              finish_q, busy_q;

   logic              entry;
   logic [DVS_W:0]    trial;
   logic              ge;
   logic [DVS_W-1:0]  rem_d;
   logic [DIVD_W-1:0] quo_d;
   logic [DIVD_W-1:0] wpm_dvd, acc_dvd;
   logic              last_iter;

   assign entry     = (state == 3'd2) && (state_prev_q != 3'd2);
   assign last_iter = (iter_q == ITER_W'(DIVD_W - 1));

   // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
   assign trial = {rem_q, quo_q[DIVD_W-1]};
   assign ge    = (trial >= {1'b0, dvs_q});
   assign rem_d = ge ? DVS_W'(trial - {1'b0, dvs_q}) : trial[DVS_W-1:0];
   assign quo_d = {quo_q[DIVD_W-2:0], ge};

   assign wpm_dvd = DIVD_W'(correct_q) * DIVD_W'(12);
   assign acc_dvd = DIVD_W'(correct_q) * DIVD_W'(100);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q        <= IDLE;
         state_prev_q <= 3'd0;
         stop_q       <= 1'b0;
         total_q      <= '0;
         correct_q    <= '0;
         secs_q       <= '0;
         rem_q        <= '0;
         dvs_q        <= '0;
         quo_q        <= '0;
         iter_q       <= '0;
         wpm_q        <= '0;
         acc_q        <= '0;
         finish_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_prev_q <= state;
         finish_q     <= 1'b0;
         if (entry) begin
            // Fresh entry into the typing state abandons whatever was in flight.
            fsm_q     <= RUN;
            stop_q    <= 1'b0;
            total_q   <= '0;
            correct_q <= '0;
            secs_q    <= '0;
            iter_q    <= '0;
            wpm_q     <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
         end else begin
            case (fsm_q)
               IDLE: ;
               RUN: begin
                  if (state == 3'd2) begin
                     if (key_valid && !(&total_q))
                        total_q <= total_q + 1'b1;
                     if (key_valid && key_correct && !(&correct_q))
                        correct_q <= correct_q + 1'b1;
                     if (sec_tick && !(&secs_q))
                        secs_q <= secs_q + 1'b1;
                  end else if (state == 3'd3) begin
                     // First cycle freezes the counters; the next loads the wpm division.
                     stop_q <= 1'b1;
                     if (stop_q) begin
                        fsm_q  <= DIV_W;
                        busy_q <= 1'b1;
                        quo_q  <= wpm_dvd;
                        rem_q  <= '0;
                        dvs_q  <= (secs_q == '0) ? DVS_W'(1) : DVS_W'(secs_q);
                        iter_q <= '0;
                     end
                  end else begin
                     fsm_q  <= IDLE;
                     stop_q <= 1'b0;
                  end
               end
               DIV_W: begin
                  iter_q <= iter_q + 1'b1;
                  quo_q  <= quo_d;
                  rem_q  <= rem_d;
                  if (last_iter) begin
                     wpm_q  <= (quo_d > DIVD_W'(MAX_WPM)) ? 10'(MAX_WPM) : quo_d[9:0];
                     fsm_q  <= DIV_A;
                     iter_q <= '0;
                     rem_q  <= '0;
                     // No keys: divide 0 by 1 so the phase length stays fixed and the result is 0.
                     quo_q  <= (total_q == '0) ? '0 : acc_dvd;
                     dvs_q  <= (total_q == '0) ? DVS_W'(1) : DVS_W'(total_q);
                  end
               end
               DIV_A: begin
                  iter_q <= iter_q + 1'b1;
                  quo_q  <= quo_d;
                  rem_q  <= rem_d;
                  if (last_iter) begin
                     acc_q    <= quo_d[9:0];
                     fsm_q    <= DONE;
                     busy_q   <= 1'b0;
                     finish_q <= 1'b1;
                  end
               end
               DONE: begin
                  fsm_q  <= IDLE;
                  stop_q <= 1'b0;
               end
               default: fsm_q <= IDLE;
            endcase
         end
      end
   end

   assign wpm    = wpm_q;
   assign acc    = acc_q;
   assign finish = finish_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_typing_scorer.sv
// Directed bench for typing_scorer: run scenarios with hand-computed wpm/acc and latency.
module tb_typing_scorer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic       key_valid, key_correct, sec_tick;
   logic [9:0] wpm, acc;
   logic       finish, busy;

   int pass_cnt = 0;
   int total_cnt = 0;
   int fin_count = 0;

   typing_scorer dut (
      .clk(clk), .rst(rst), .state(state), .key_valid(key_valid),
      .key_correct(key_correct), .sec_tick(sec_tick),
      .wpm(wpm), .acc(acc), .finish(finish), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (finish === 1'b1) fin_count++;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic v, input logic c, input logic t);
      key_valid = v; key_correct = c; sec_tick = t;
      step();
      key_valid = 1'b0; key_correct = 1'b0; sec_tick = 1'b0;
   endtask

   task automatic start_run();
      state = 3'd2;
      step();
   endtask

   task automatic idle(input int n);
      state = 3'd0;
      repeat (n) step();
   endtask

   // Moves to the result screen and waits (bounded) for finish; n = cycles to finish, b = first busy cycle.
   task automatic wait_finish(output int n, output int b);
      n = -1; b = -1;
      state = 3'd3;
      for (int i = 1; i <= 200; i++) begin
         step();
         key_valid = 1'b0; key_correct = 1'b0; sec_tick = 1'b0;
         if (busy === 1'b1 && b < 0) b = i;
         if (finish === 1'b1) begin n = i; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; state = 3'd0; key_valid = 0; key_correct = 0; sec_tick = 0;
      repeat (2) step();
      total_cnt++;
      if (wpm !== 10'd0 || acc !== 10'd0 || finish !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_outputs: wpm=%0d acc=%0d finish=%b busy=%b, want 0 0 0 0", wpm, acc, finish, busy);
      else pass_cnt++;
      rst = 1'b0;
      step();
      $display("reset: wpm=%0d acc=%0d", wpm, acc);
   endtask

   task automatic test_basic_run();
      int n, b, f0;
      start_run();
      for (int i = 0; i < 50; i++) drive(1'b1, i < 45, 1'b0);
      for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b1);
      f0 = fin_count;
      wait_finish(n, b);
      total_cnt++;
      if (n !== 42) $display("FAIL t1_latency: got %0d cycles, want 42", n); else pass_cnt++;
      total_cnt++;
      if (b !== 2) $display("FAIL t1_busy_start: got cycle %0d, want 2", b); else pass_cnt++;
      total_cnt++;
      if (wpm !== 10'd18 || acc !== 10'd90)
         $display("FAIL t1_result: wpm=%0d acc=%0d, want 18 90", wpm, acc);
      else pass_cnt++;
      step();
      total_cnt++;
      if (finish !== 1'b0 || busy !== 1'b0)
         $display("FAIL t1_pulse_width: finish=%b busy=%b, want 0 0", finish, busy);
      else pass_cnt++;
      repeat (40) step();
      total_cnt++;
      if (wpm !== 10'd18 || acc !== 10'd90 || fin_count - f0 !== 1)
         $display("FAIL t1_hold: wpm=%0d acc=%0d finishes=%0d, want 18 90 1", wpm, acc, fin_count - f0);
      else pass_cnt++;
      $display("t1: cycles=%0d wpm=%0d acc=%0d", n, wpm, acc);
   endtask

   task automatic test_zero_time();
      int n, b;
      idle(2);
      start_run();
      for (int i = 0; i < 9; i++) drive(1'b1, i < 7, 1'b0);
      wait_finish(n, b);
      total_cnt++;
      if (n !== 42 || wpm !== 10'd84 || acc !== 10'd77)
         $display("FAIL t2_zero_time: n=%0d wpm=%0d acc=%0d, want 42 84 77", n, wpm, acc);
      else pass_cnt++;
      $display("t2: wpm=%0d acc=%0d", wpm, acc);
   endtask

   task automatic test_saturation();
      int n, b;
      idle(2);
      start_run();
      key_valid = 1'b1; key_correct = 1'b1;
      repeat (4100) step();
      key_valid = 1'b0; key_correct = 1'b0;
      drive(1'b0, 1'b0, 1'b1);
      wait_finish(n, b);
      total_cnt++;
      if (n !== 42 || wpm !== 10'd999 || acc !== 10'd100)
         $display("FAIL t3a_saturate: n=%0d wpm=%0d acc=%0d, want 42 999 100", n, wpm, acc);
      else pass_cnt++;
      $display("t3a: wpm=%0d acc=%0d", wpm, acc);
      idle(2);
      start_run();
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
      wait_finish(n, b);
      total_cnt++;
      if (n !== 42 || wpm !== 10'd0 || acc !== 10'd0)
         $display("FAIL t3b_no_keys: n=%0d wpm=%0d acc=%0d, want 42 0 0", n, wpm, acc);
      else pass_cnt++;
      $display("t3b: finish_cycle=%0d wpm=%0d acc=%0d", n, wpm, acc);
   endtask

   task automatic test_edge_events();
      int n, b;
      idle(2);
      start_run();
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++)  drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
      // Key arriving in the very cycle the state leaves 2 must be ignored.
      key_valid = 1'b1; key_correct = 1'b1;
      wait_finish(n, b);
      total_cnt++;
      if (wpm !== 10'd12) $display("FAIL t4_wpm: got %0d, want 12", wpm); else pass_cnt++;
      total_cnt++;
      if (acc !== 10'd50) $display("FAIL t4_acc: got %0d, want 50", acc); else pass_cnt++;
      $display("t4: wpm=%0d acc=%0d", wpm, acc);
   endtask

   task automatic test_abort_restart();
      int n, b, f0;
      // Asynchronous reset ten cycles into the wpm division.
      idle(2);
      start_run();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1);
      f0 = fin_count;
      state = 3'd3;
      repeat (12) step();
      rst = 1'b1;
      #1;
      total_cnt++;
      if (wpm !== 10'd0 || acc !== 10'd0 || busy !== 1'b0)
         $display("FAIL t5_rst_clear: wpm=%0d acc=%0d busy=%b, want 0 0 0", wpm, acc, busy);
      else pass_cnt++;
      step();
      rst = 1'b0;
      repeat (60) step();
      total_cnt++;
      if (fin_count !== f0) $display("FAIL t5_rst_nofinish: finishes=%0d, want 0", fin_count - f0);
      else pass_cnt++;
      $display("t5a: reset mid-division, finishes=%0d", fin_count - f0);

      // Leaving the typing state for the menu aborts the run.
      start_run();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1);
      f0 = fin_count;
      idle(60);
      total_cnt++;
      if (fin_count !== f0 || busy !== 1'b0)
         $display("FAIL t5_abort: finishes=%0d busy=%b, want 0 0", fin_count - f0, busy);
      else pass_cnt++;
      $display("t5b: abort, finishes=%0d", fin_count - f0);

      // Re-entering state 2 during the accuracy division restarts cleanly.
      start_run();
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1);
      f0 = fin_count;
      state = 3'd3;
      repeat (27) step();
      total_cnt++;
      if (wpm !== 10'd36 || busy !== 1'b1)
         $display("FAIL t5_mid_diva: wpm=%0d busy=%b, want 36 1", wpm, busy);
      else pass_cnt++;
      state = 3'd2;
      step();
      total_cnt++;
      if (wpm !== 10'd0 || acc !== 10'd0 || busy !== 1'b0)
         $display("FAIL t5_restart_clear: wpm=%0d acc=%0d busy=%b, want 0 0 0", wpm, acc, busy);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) drive(1'b1, i < 2, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (fin_count !== f0) $display("FAIL t5_restart_nofinish: finishes=%0d, want 0", fin_count - f0);
      else pass_cnt++;
      wait_finish(n, b);
      total_cnt++;
      if (n !== 42 || wpm !== 10'd24 || acc !== 10'd66)
         $display("FAIL t5_restart_run: n=%0d wpm=%0d acc=%0d, want 42 24 66", n, wpm, acc);
      else pass_cnt++;
      $display("t5c: restarted run wpm=%0d acc=%0d", wpm, acc);
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_zero_time();
      test_saturation();
      test_edge_events();
      test_abort_restart();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
